lsq_in_order: RTL
=================

Name: lsq_in_order

Overview:
- Circular in-order load/store queue between dispatch/rename and the memory unit.
- Captures memory ops at dispatch and snoops the CDB for missing operands.
- Presents the oldest op to the memory unit once its operands are ready.
- Loads issue speculatively in program order. Stores issue only when they are the ROB head, so memory writes are never speculative.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2
ROB_IDX_W, 4, width of ROB index / operand tag

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; discard all entries
disp_valid  in  1  dispatch presents a memory op
disp_ready  out  1  queue can accept this cycle
disp_is_store  in  1  1=store, 0=load
disp_funct3  in  3  RV32I width/sign field
disp_imm  in  32  sign-extended offset
disp_rs1_ready  in  1  rs1 value valid at dispatch
disp_rs1_tag  in  ROB_IDX_W  producer ROB index when not ready
disp_rs1_data  in  32  rs1 value
disp_rs2_ready  in  1  rs2 value valid (ignored for loads)
disp_rs2_tag  in  ROB_IDX_W  producer of rs2
disp_rs2_data  in  32  rs2 value
disp_rob_idx  in  ROB_IDX_W  ROB slot of this op
cdb_valid  in  1  result broadcast
cdb_rob_idx  in  ROB_IDX_W  tag of broadcast
cdb_data  in  32  broadcast value
rob_head_idx  in  ROB_IDX_W  current ROB head
iss_valid  out  1  head op ready for memory unit
iss_ready  in  1  memory unit accepts (not stalled)
iss_is_store  out  1  op type
iss_funct3  out  3  width/sign
iss_addr  out  32  rs1+imm, unaligned byte address
iss_wdata  out  32  rs2 value, unshifted
iss_rob_idx  out  ROB_IDX_W  ROB slot
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: DEPTH entries plus head/tail pointers carrying an extra wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - count = tail - head, computed modulo 2*DEPTH.
- Reset or flush, at the clock edge:
  - head = tail = 0 and all entry valid bits cleared, so count=0.
  - Combinational outputs then follow: iss_valid=0, disp_ready=1, other iss_* outputs 0.
- While flush is high, disp_ready=0 and iss_valid=0; nothing is allocated or popped that cycle.
- Allocate when disp_valid && disp_ready.
  - Entry is written at tail; tail increments, wrapping DEPTH-1 -> 0 with the wrap bit toggled.
  - disp_ready = !full && !flush. There is no same-cycle bypass when full, even if a pop occurs in that cycle.
- Wakeup:
  - Each cycle, every valid entry with a not-ready operand whose tag equals cdb_rob_idx under cdb_valid sets that operand ready and latches cdb_data.
  - If an op is dispatched not-ready with a tag matching the same-cycle CDB broadcast, the entry is written ready with cdb_data.
  - Loads mark rs2 ready at allocation.
- Issue (combinational from the head entry):
  - Load: iss_valid = !empty && rs1 ready.
  - Store: iss_valid = !empty && rs1 ready && rs2 ready && head rob_idx == rob_head_idx.
  - iss_addr = rs1 + imm, modulo 2^32.
  - Pop when iss_valid && iss_ready: head increments and the entry is cleared.
- No age reordering; a load behind an unissued store waits, so no store-to-load forwarding is needed.
- Simultaneous allocate and pop: count unchanged; both pointers advance.
- iss_* outputs hold stable while iss_valid && !iss_ready.

Decomposition:
- Shared package rv32i_types gets lsq_entry_t (valid, is_store, funct3, imm, rs1/rs2 ready/tag/data, rob_idx) and the clog2 width constant.
- No sub-module; a generic CDB tag-match function also lives in the package for reuse by reservation stations.

Test Plan:
- Reset then dispatch load (rs1 ready=0x1000, imm=4, rob_idx=2) -> next cycle iss_valid=1, iss_addr=0x1004, count=1; iss_ready=1 -> count=0.
- Dispatch store rob_idx=5 with operands ready, rob_head_idx=3 -> iss_valid=0. rob_head_idx=5 -> iss_valid=1, iss_wdata = rs2.
- Load with rs1 tag=7 not ready; cdb_valid, tag=7, data=0x2000 -> next cycle iss_addr=0x2000+imm. Repeat with dispatch and CDB in the same cycle -> captured ready.
- Fill DEPTH entries with iss_ready=0 -> disp_ready=0, count=8. Pop one while dispatching -> disp_ready still 0 that cycle, count 7 next. Run 20 ops total to check pointer wrap and in-order issue.
- Hold iss_ready=0 for 5 cycles with iss_valid=1 -> outputs stable; then accept -> next entry presented.
- Flush with 4 entries valid while dispatching -> dispatch ignored, count=0, iss_valid=0 next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I back-end types: LSQ entry layout and the CDB wakeup helper.
// Structure fields are sized by the package constants; instantiating parameters must agree with them.
package rv32i_types;

  localparam int XLEN      = 32;
  localparam int TAG_W     = 4;
  localparam int LSQ_DEPTH = 8;
  localparam int LSQ_CNT_W = $clog2(LSQ_DEPTH) + 1;

  typedef struct packed {
    logic             valid;
    logic             is_store;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_data;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rob_idx;
  } lsq_entry_t;

  // True when a still-waiting operand is satisfied by the current broadcast.
  function automatic logic cdb_wakes(input logic             rdy,
                                     input logic [TAG_W-1:0] tag,
                                     input logic             cdb_vld,
                                     input logic [TAG_W-1:0] cdb_tag);
    return !rdy && cdb_vld && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/lsq_in_order.sv
// In-order circular load/store queue: captures memory ops at dispatch, snoops the CDB,
// and presents the oldest op to the memory unit; stores wait until they reach the ROB head.
module lsq_in_order
  import rv32i_types::*;
#(
  parameter int DEPTH     = LSQ_DEPTH,
  parameter int ROB_IDX_W = TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic                       disp_is_store,
  input  logic [2:0]                 disp_funct3,
  input  logic [31:0]                disp_imm,
  input  logic                       disp_rs1_ready,
  input  logic [ROB_IDX_W-1:0]       disp_rs1_tag,
  input  logic [31:0]                disp_rs1_data,
  input  logic                       disp_rs2_ready,
  input  logic [ROB_IDX_W-1:0]       disp_rs2_tag,
  input  logic [31:0]                disp_rs2_data,
  input  logic [ROB_IDX_W-1:0]       disp_rob_idx,
  input  logic                       cdb_valid,
  input  logic [ROB_IDX_W-1:0]       cdb_rob_idx,
  input  logic [31:0]                cdb_data,
  input  logic [ROB_IDX_W-1:0]       rob_head_idx,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic                       iss_is_store,
  output logic [2:0]                 iss_funct3,
  output logic [31:0]                iss_addr,
  output logic [31:0]                iss_wdata,
  output logic [ROB_IDX_W-1:0]       iss_rob_idx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IW:0] head;
  logic [IW:0] tail;
  lsq_entry_t  q [DEPTH];
  lsq_entry_t  hd;
  lsq_entry_t  new_e;
  logic        empty;
  logic        full;
  logic        do_alloc;
  logic        do_pop;
  logic        rs1_wake;
  logic        rs2_wake;

  assign hd       = q[head[IW-1:0]];
  assign empty    = (head == tail);
  assign full     = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
  assign count    = tail - head;
  assign disp_ready = !full && !flush;
  assign do_alloc = disp_valid && disp_ready;
  assign do_pop   = iss_valid && iss_ready;

  assign rs1_wake = cdb_wakes(disp_rs1_ready, disp_rs1_tag, cdb_valid, cdb_rob_idx);
  assign rs2_wake = cdb_wakes(disp_rs2_ready, disp_rs2_tag, cdb_valid, cdb_rob_idx);

  always_comb begin
    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.is_store = disp_is_store;
    new_e.funct3   = disp_funct3;
    new_e.imm      = disp_imm;
    new_e.rob_idx  = disp_rob_idx;
    new_e.rs1_tag  = disp_rs1_tag;
    new_e.rs1_rdy  = disp_rs1_ready || rs1_wake;
    new_e.rs1_data = rs1_wake ? cdb_data : disp_rs1_data;
    new_e.rs2_tag  = disp_rs2_tag;
    // Loads have no rs2 dependency, so they never wait on it.
    if (disp_is_store) begin
      new_e.rs2_rdy  = disp_rs2_ready || rs2_wake;
      new_e.rs2_data = rs2_wake ? cdb_data : disp_rs2_data;
    end else begin
      new_e.rs2_rdy  = 1'b1;
      new_e.rs2_data = disp_rs2_data;
    end
  end

  always_comb begin
    iss_valid = !flush && !empty && hd.valid && hd.rs1_rdy &&
                (!hd.is_store || (hd.rs2_rdy && (hd.rob_idx == rob_head_idx)));
  end

  always_comb begin
    iss_is_store = 1'b0;
    iss_funct3   = '0;
    iss_addr     = '0;
    iss_wdata    = '0;
    iss_rob_idx  = '0;
    if (hd.valid) begin
      iss_is_store = hd.is_store;
      iss_funct3   = hd.funct3;
      iss_addr     = hd.rs1_data + hd.imm;
      iss_wdata    = hd.rs2_data;
      iss_rob_idx  = hd.rob_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && cdb_wakes(q[i].rs1_rdy, q[i].rs1_tag, cdb_valid, cdb_rob_idx)) begin
          q[i].rs1_rdy  <= 1'b1;
          q[i].rs1_data <= cdb_data;
        end
        if (q[i].valid && cdb_wakes(q[i].rs2_rdy, q[i].rs2_tag, cdb_valid, cdb_rob_idx)) begin
          q[i].rs2_rdy  <= 1'b1;
          q[i].rs2_data <= cdb_data;
        end
      end
      if (do_pop) begin
        q[head[IW-1:0]] <= '0;
        head            <= head + 1'b1;
      end
      if (do_alloc) begin
        q[tail[IW-1:0]] <= new_e;
        tail            <= tail + 1'b1;
      end
    end
  end

endmodule
